// File: rtl/va_logicvdd_ddr_serializer_if.sv
// Parallel-load / serial-out bus of the LogicVDD DDR serializer.
// master: word source (drives din/load, observes ready and the serial pair).
// slave:  the serializer itself.
interface va_logicvdd_ddr_serializer_if #(
  parameter int N = 8
);
  logic [N-1:0] din;    // parallel word, din[0] is transmitted first
  logic         load;   // load request, sampled on rising clk edges only
  logic         ready;  // a load sampled at the next rising edge is accepted
  logic         dout;   // serial data, one bit per clk edge
  logic         doutb;  // complement of dout

  modport master (output din, load, input ready, dout, doutb);
  modport slave  (input din, load, output ready, dout, doutb);
endinterface

// File: rtl/va_logicvdd_ddr_serializer.sv
// Double-data-rate serializer: latches an N-bit word on a load handshake and
// sends it LSB-first, one bit on every clk edge (falling edges carry even bit
// indices, rising edges odd ones). Back-to-back words stream without a gap.
// Optional feature macro: DDR_TX_PARITY_EN appends an even-parity bit as bit
// index N, making the frame N+1 bits long (half-cycle idle gap between words).
// Supplies and analogue output levels of the behavioural cell are not modelled;
// logic 1/0 stand for VDD/VSS.
//
// Implementation: all frame state lives in rising-edge registers. The falling
// edge is fully determined by that state (load is never sampled there), so the
// rising-edge logic folds "falling step + rising step" into one update, and a
// single falling-edge flop only holds the bit launched on the falling edge.
// The serial output selects the flop of the most recent edge.
module va_logicvdd_ddr_serializer #(
  parameter int N = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  va_logicvdd_ddr_serializer_if.slave   bus
);

`ifdef DDR_TX_PARITY_EN
  localparam int L = N + 1;
`else
  localparam int L = N;
`endif
  localparam int              CW    = $clog2(L + 1);
  localparam logic [CW-1:0]   ZERO  = '0;
  localparam logic [CW-1:0]   ONE   = CW'(1);
  localparam logic [CW-1:0]   TWO   = CW'(2);
  localparam logic [CW-1:0]   L_CNT = CW'(L);

  if (N < 2 || N > 32 || (N % 2) != 0) begin : g_bad_n
    $error("va_logicvdd_ddr_serializer: N must be even and within [2:32]");
  end

  // Rising-edge state: shift register and remaining-bit counter as seen
  // during the high phase of clk.
  logic [L-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Bits launched on the last rising / falling edge.
  logic          dbit_p_q, dbit_p_d;
  logic          dbit_n_q, dbit_n_d;

  // State after the falling edge that precedes the next rising edge.
  logic [L-1:0]  sr_f;
  logic [CW-1:0] cnt_f;
  logic [L-1:0]  load_word;

`ifdef DDR_TX_PARITY_EN
  assign load_word = {^bus.din, bus.din};
`else
  assign load_word = bus.din;
`endif

  // Next state: falling-edge shift, then rising-edge shift, then load.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    dbit_n_d = 1'b0;
    cnt_f    = cnt_q;
    sr_f     = sr_q;
    if (cnt_q != ZERO) begin
      dbit_n_d = sr_q[0];
      cnt_f    = cnt_q - ONE;
      sr_f     = sr_q >> 1;
    end

    dbit_p_d = 1'b0;
    cnt_d    = cnt_f;
    sr_d     = sr_f;
    if (cnt_f != ZERO) begin
      dbit_p_d = sr_f[0];
      cnt_d    = cnt_f - ONE;
      sr_d     = sr_f >> 1;
    end

    // A word is accepted while the previous frame is on its last bit or idle,
    // which is what makes back-to-back frames gapless.
    if (bus.load && (cnt_f <= ONE)) begin
      sr_d  = load_word;
      cnt_d = L_CNT;
    end
  end

  // Rising-edge registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q     <= '0;
      cnt_q    <= ZERO;
      dbit_p_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      dbit_p_q <= dbit_p_d;
    end
  end

  // Falling-edge register holding the even-index bit.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      dbit_n_q <= 1'b0;
    end else begin
      dbit_n_q <= dbit_n_d;
    end
  end

  // During the high phase the rising-edge bit is current, during the low
  // phase the falling-edge bit is.
  assign bus.dout  = clk ? dbit_p_q : dbit_n_q;
  assign bus.doutb = ~bus.dout;

  // Ready when idle, or on the last bit while clk is low. In the low phase
  // the true count is one less than cnt_q (unless cnt_q is already zero).
  assign bus.ready = !rst && (clk ? (cnt_q == ZERO) : (cnt_q <= TWO));

endmodule

// File: tb/tb_va_logicvdd_ddr_serializer.sv
// Self-checking bench for va_logicvdd_ddr_serializer (N=8). A queue-based
// model of the serial stream is compared against the DUT after every clk edge;
// directed frames are also checked against hand-computed literals.
// Build with +define+DDR_TX_PARITY_EN to exercise the parity frame.
`timescale 1ns/1ps
module tb_va_logicvdd_ddr_serializer;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  va_logicvdd_ddr_serializer_if #(.N(N)) bus_if ();

  va_logicvdd_ddr_serializer #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: queue of bits still to be sent ----------------
  bit   m_q[$];
  logic m_dbit = 1'b0;

  always @(posedge clk or negedge clk or posedge rst) begin
    int pre;
    if (rst) begin
      m_q.delete();
      m_dbit = 1'b0;
    end else begin
      pre = m_q.size();
      if (pre > 0) m_dbit = m_q.pop_front();
      else         m_dbit = 1'b0;
      if (clk && bus_if.load && pre <= 1) begin
        for (int i = 0; i < N; i++) m_q.push_back(bus_if.din[i]);
`ifdef DDR_TX_PARITY_EN
        m_q.push_back(^bus_if.din);
`endif
      end
    end
  end

  // Compare process: one sample shortly after every edge.
  always @(posedge clk or negedge clk) begin
    logic exp_ready;
    #1;
    exp_ready = !rst && (m_q.size() == 0 || (m_q.size() == 1 && !clk));
    check("model_dout",  {31'd0, bus_if.dout},  {31'd0, m_dbit});
    check("model_doutb", {31'd0, bus_if.doutb}, {31'd0, ~m_dbit});
    check("model_ready", {31'd0, bus_if.ready}, {31'd0, exp_ready});
  end

  // Capture dout/ready after each of the next n edges (bit i = edge i+1).
  task automatic capture(input int n, output logic [31:0] d,
                         output logic [31:0] r);
    d = '0;
    r = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk or negedge clk);
      #1;
      d[i] = bus_if.dout;
      r[i] = bus_if.ready;
    end
  endtask

  task automatic sync_low();
    @(negedge clk);
    #2;
  endtask

  // Present a word over exactly one rising edge.
  task automatic pulse_load(input logic [N-1:0] w);
    sync_low();
    bus_if.din  = w;
    bus_if.load = 1'b1;
    @(posedge clk);
    #2;
    bus_if.load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, r;
    rst         = 1'b1;
    bus_if.din  = '0;
    bus_if.load = 1'b0;

    // 1. reset state and release
    repeat (4) @(posedge clk);
    sync_low();
    check("rst_dout",  {31'd0, bus_if.dout},  32'd0);
    check("rst_doutb", {31'd0, bus_if.doutb}, 32'd1);
    check("rst_ready", {31'd0, bus_if.ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("release_ready", {31'd0, bus_if.ready}, 32'd1);

    // 2. single frame 0xA5 -> 1,0,1,0,0,1,0,1 then idle
    pulse_load(8'hA5);
    capture(8, d, r);
    check("a5_bits",  d, 32'h0000_00A5);
    check("a5_ready", r, 32'h0000_00C0);
    capture(1, d, r);
    check("a5_idle_dout",  d, 32'd0);
    check("a5_idle_ready", r, 32'd1);

    // 3. 0xFF then 0x00 back-to-back with load held high
    sync_low();
    bus_if.din  = 8'hFF;
    bus_if.load = 1'b1;
    @(posedge clk);
    #2;
    bus_if.din = 8'h00;
    fork
      capture(16, d, r);
      begin
        repeat (4) @(posedge clk);
        #2;
        bus_if.load = 1'b0;
      end
    join
    check("b2b_bits",  d, 32'h0000_00FF);
    check("b2b_ready", r, 32'h0000_C040);

    // 4. reset after 3 bits of 0xFF; load during reset is discarded
    pulse_load(8'hFF);
    capture(3, d, r);
    check("abort_first_bits", d, 32'h0000_0007);
    #1;
    rst = 1'b1;
    #1;
    check("abort_dout",  {31'd0, bus_if.dout},  32'd0);
    check("abort_doutb", {31'd0, bus_if.doutb}, 32'd1);
    check("abort_ready", {31'd0, bus_if.ready}, 32'd0);
    bus_if.load = 1'b1;
    repeat (2) @(posedge clk);
    sync_low();
    bus_if.load = 1'b0;
    rst = 1'b0;
    #1;
    check("abort_release_ready", {31'd0, bus_if.ready}, 32'd1);
    capture(8, d, r);
    check("abort_no_bits",  d, 32'd0);
    check("abort_idle_rdy", r, 32'h0000_00FF);

    // 5. load and din change mid-frame are ignored
    pulse_load(8'h0F);
    fork
      capture(8, d, r);
      begin
        @(posedge clk);
        #2;
        bus_if.din  = 8'h00;
        bus_if.load = 1'b1;
        @(posedge clk);
        #2;
        bus_if.load = 1'b0;
      end
    join
    check("midload_bits",  d, 32'h0000_000F);
    check("midload_ready", r, 32'h0000_00C0);

    // 6. frame 0x07 (with parity: 9 bits, last on a falling edge), then a
    //    load at the very next rising edge
    pulse_load(8'h07);
    capture(9, d, r);
`ifdef DDR_TX_PARITY_EN
    check("w07_bits",  d, 32'h0000_0107);
    check("w07_ready", r, 32'h0000_0100);
`else
    check("w07_bits",  d, 32'h0000_0007);
    check("w07_ready", r, 32'h0000_01C0);
`endif
    bus_if.din  = 8'h02;
    bus_if.load = 1'b1;
    @(posedge clk);
    #2;
    bus_if.load = 1'b0;
    capture(2, d, r);
    check("next_load_bits", d, 32'h0000_0002);

    repeat (12) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
